// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor
// Captures every retired instruction (PC, instruction word, cycle stamp) in a
// circular buffer. Capture stops on a programmable PC match or when no
// instruction has retired for TIMEOUT cycles. Once stopped, the buffer is
// drained oldest-first over a valid/ready stream.
module cpu_trace_monitor #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 8,
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,          // asynchronous, active low
    input  logic                     clear,
    input  logic                     retire_valid,
    input  logic [PC_W-1:0]          retire_pc,
    input  logic [INSTR_W-1:0]       retire_instr,
    input  logic                     halt_en,
    input  logic [PC_W-1:0]          halt_pc,
    input  logic                     drain_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [CYC_W-1:0]         out_cycle,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted,
    output logic                     timeout,
    output logic                     overflow,
    output logic                     done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Trace storage (no reset: contents are only read after being written)
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [CYC_W-1:0]   mem_cycle [DEPTH];

    state_t             state_q,     state_d;
    logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [CYC_W-1:0]   cyc_q,       cyc_d;
    logic [WD_W-1:0]    wdog_q,      wdog_d;
    logic               timeout_q,   timeout_d;
    logic               overflow_q,  overflow_d;
    logic               out_valid_q, out_valid_d;
    logic [PC_W-1:0]    out_pc_q,    out_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [CYC_W-1:0]   out_cycle_q, out_cycle_d;

    logic               mem_we;
    logic [PTR_W-1:0]   oldest_ptr;
    logic [PTR_W-1:0]   rd_addr;
    logic [PC_W-1:0]    rd_pc;
    logic [INSTR_W-1:0] rd_instr;
    logic [CYC_W-1:0]   rd_cycle;

    // With a full buffer the low count bits are zero, so oldest == wr_ptr.
    assign oldest_ptr = wr_ptr_q - count_q[PTR_W-1:0];
    // The first entry of a drain is fetched while still in HALTED.
    assign rd_addr    = (state_q == ST_HALTED) ? oldest_ptr : rd_ptr_q;
    assign rd_pc      = mem_pc[rd_addr];
    assign rd_instr   = mem_instr[rd_addr];
    assign rd_cycle   = mem_cycle[rd_addr];

    // Next-state, pointer, counter and output-register logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cyc_d       = cyc_q;
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_cycle_d = out_cycle_q;
        mem_we      = 1'b0;

        if (clear) begin
            state_d     = ST_RUN;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            cyc_d       = '0;
            wdog_d      = '0;
            timeout_d   = 1'b0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
            out_pc_d    = '0;
            out_instr_d = '0;
            out_cycle_d = '0;
        end else begin
            // Free-running stamp that sticks at its maximum value
            if (cyc_q != {CYC_W{1'b1}}) begin
                cyc_d = cyc_q + 1'b1;
            end

            unique case (state_q)
                ST_RUN: begin
                    if (retire_valid) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        wdog_d   = '0;
                        if (count_q == FULL_COUNT) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                        if (halt_en && (retire_pc == halt_pc)) begin
                            state_d = ST_HALTED;
                        end
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                        if (wdog_q == WD_LAST) begin
                            state_d   = ST_HALTED;
                            timeout_d = 1'b1;
                        end
                    end
                end

                ST_HALTED: begin
                    if (drain_start) begin
                        if (count_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d     = ST_DRAIN;
                            out_valid_d = 1'b1;
                            out_pc_d    = rd_pc;
                            out_instr_d = rd_instr;
                            out_cycle_d = rd_cycle;
                            rd_ptr_d    = oldest_ptr + 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        count_d = count_q - 1'b1;
                        if (count_q == ONE_COUNT) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b0;
                        end else begin
                            out_pc_d    = rd_pc;
                            out_instr_d = rd_instr;
                            out_cycle_d = rd_cycle;
                            rd_ptr_d    = rd_ptr_q + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // Left only through clear or reset
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Control and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cyc_q       <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_cycle_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cyc_q       <= cyc_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_cycle_q <= out_cycle_d;
        end
    end

    // Trace buffer write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_pc[wr_ptr_q]    <= retire_pc;
            mem_instr[wr_ptr_q] <= retire_instr;
            mem_cycle[wr_ptr_q] <= cyc_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_cycle = out_cycle_q;
    assign out_last  = (state_q == ST_DRAIN) && (count_q == ONE_COUNT);
    assign count     = count_q;
    assign halted    = (state_q != ST_RUN);
    assign timeout   = timeout_q;
    assign overflow  = overflow_q;
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed testbench for cpu_trace_monitor: halt/drain, wrap, backpressure,
// watchdog, empty drain, clear during drain and asynchronous reset.
module tb_cpu_trace_monitor;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 8;
    localparam int CYC_W   = 16;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clear = 1'b0;
    logic               retire_valid = 1'b0;
    logic [PC_W-1:0]    retire_pc = '0;
    logic [INSTR_W-1:0] retire_instr = '0;
    logic               halt_en = 1'b0;
    logic [PC_W-1:0]    halt_pc = '0;
    logic               drain_start = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [CYC_W-1:0]   out_cycle;
    logic               out_last;
    logic [3:0]         count;
    logic               halted;
    logic               timeout;
    logic               overflow;
    logic               done;

    int checks = 0;
    int errors = 0;

    cpu_trace_monitor #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .halt_en(halt_en), .halt_pc(halt_pc), .drain_start(drain_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_cycle(out_cycle), .out_last(out_last),
        .count(count), .halted(halted), .timeout(timeout),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] instr_of(input int pc);
        return 32'hC0DE_0000 | 32'(pc * 3 + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic retire(input int pc);
        retire_valid = 1'b1;
        retire_pc    = PC_W'(pc);
        retire_instr = instr_of(pc);
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic pulse_drain();
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || halted !== 1'b0 || done !== 1'b0 ||
            timeout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v=%b l=%b h=%b d=%b t=%b o=%b expected all 0",
                     out_valid, out_last, halted, done, timeout, overflow);
        end
        checks++;
        if (count !== 4'd0 || out_pc !== '0 || out_instr !== '0 || out_cycle !== '0) begin
            errors++;
            $display("FAIL reset_data: got count=%0d pc=%0d instr=%h cyc=%0d expected 0",
                     count, out_pc, out_instr, out_cycle);
        end
        reset = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        halt_en = 1'b1;
        halt_pc = 4'd7;
        out_ready = 1'b1;
        do_clear();
        for (int i = 0; i < 8; i++) begin
            retire(i);
            if (i == 6) begin
                checks++;
                if (halted !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_halt: got halted=%b expected 0", halted);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || count !== 4'd8 || overflow !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL basic_halt: got h=%b count=%0d ovf=%b to=%b expected h=1 count=8 ovf=0 to=0",
                     halted, count, overflow, timeout);
        end
        pulse_drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== PC_W'(k) || out_instr !== instr_of(k) ||
                out_cycle !== CYC_W'(k) || out_last !== (k == 7)) begin
                errors++;
                $display("FAIL basic_entry[%0d]: got v=%b pc=%0d instr=%h cyc=%0d last=%b expected v=1 pc=%0d instr=%h cyc=%0d last=%b",
                         k, out_valid, out_pc, out_instr, out_cycle, out_last,
                         k, instr_of(k), k, (k == 7));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || count !== 4'd0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: got v=%b done=%b count=%0d h=%b expected v=0 done=1 count=0 h=1",
                     out_valid, done, count, halted);
        end
        $display("test_basic done");
    endtask

    task automatic test_wrap();
        halt_en = 1'b1;
        halt_pc = 4'd10;
        out_ready = 1'b1;
        do_clear();
        for (int i = 0; i < 11; i++) retire(i);
        checks++;
        if (halted !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap_halt: got h=%b count=%0d ovf=%b expected h=1 count=8 ovf=1",
                     halted, count, overflow);
        end
        pulse_drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== PC_W'(k + 3) || out_cycle !== CYC_W'(k + 3) ||
                out_last !== (k == 7)) begin
                errors++;
                $display("FAIL wrap_entry[%0d]: got v=%b pc=%0d cyc=%0d last=%b expected v=1 pc=%0d cyc=%0d last=%b",
                         k, out_valid, out_pc, out_cycle, out_last, k + 3, k + 3, (k == 7));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: got done=%b v=%b expected done=1 v=0", done, out_valid);
        end
        $display("test_wrap done");
    endtask

    task automatic test_backpressure();
        halt_en = 1'b1;
        halt_pc = 4'd3;
        out_ready = 1'b1;
        do_clear();
        for (int i = 0; i < 4; i++) retire(i);
        pulse_drain();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
            errors++;
            $display("FAIL bp_first: got v=%b pc=%0d expected v=1 pc=0", out_valid, out_pc);
        end
        tick();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 4'd1 || out_instr !== instr_of(1) || count !== 4'd3) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got v=%b pc=%0d instr=%h count=%0d expected v=1 pc=1 instr=%h count=3",
                         s, out_valid, out_pc, out_instr, count, instr_of(1));
            end
            tick();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== PC_W'(k) || out_cycle !== CYC_W'(k)) begin
                errors++;
                $display("FAIL bp_entry[%0d]: got v=%b pc=%0d cyc=%0d expected v=1 pc=%0d cyc=%0d",
                         k, out_valid, out_pc, out_cycle, k, k);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got done=%b v=%b expected done=1 v=0", done, out_valid);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_watchdog();
        halt_en = 1'b0;
        out_ready = 1'b1;
        do_clear();
        retire(5);
        retire(6);
        for (int n = 1; n <= TIMEOUT; n++) begin
            tick();
            if (n == TIMEOUT - 1) begin
                checks++;
                if (halted !== 1'b0 || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_early: got h=%b to=%b at idle %0d expected 0 0", halted, timeout, n);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || timeout !== 1'b1 || count !== 4'd2) begin
            errors++;
            $display("FAIL wd_halt: got h=%b to=%b count=%0d expected h=1 to=1 count=2",
                     halted, timeout, count);
        end
        retire(9);
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL wd_ignore: got count=%0d expected 2", count);
        end
        pulse_drain();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== PC_W'(5 + k) || out_cycle !== CYC_W'(k) ||
                out_last !== (k == 1)) begin
                errors++;
                $display("FAIL wd_entry[%0d]: got v=%b pc=%0d cyc=%0d last=%b expected v=1 pc=%0d cyc=%0d last=%b",
                         k, out_valid, out_pc, out_cycle, out_last, 5 + k, k, (k == 1));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wd_done: got done=%b expected 1", done);
        end
        $display("test_watchdog done");
    endtask

    task automatic test_empty_drain();
        bit seen_valid = 1'b0;
        halt_en = 1'b1;
        halt_pc = 4'd0;
        do_clear();
        for (int n = 0; n < TIMEOUT; n++) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (halted !== 1'b1 || timeout !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL empty_halt: got h=%b to=%b count=%0d expected h=1 to=1 count=0",
                     halted, timeout, count);
        end
        pulse_drain();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_done: got done=%b v=%b expected done=1 v=0", done, out_valid);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_valid: got out_valid seen=%b expected 0", seen_valid);
        end
        $display("test_empty_drain done");
    endtask

    task automatic test_clear_mid_drain();
        halt_en = 1'b1;
        halt_pc = 4'd3;
        out_ready = 1'b1;
        do_clear();
        for (int i = 0; i < 4; i++) retire(i);
        pulse_drain();
        tick();
        do_clear();
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || halted !== 1'b0 || done !== 1'b0 || out_pc !== '0) begin
            errors++;
            $display("FAIL clear_drain: got v=%b count=%0d h=%b done=%b pc=%0d expected all 0",
                     out_valid, count, halted, done, out_pc);
        end
        $display("test_clear_mid_drain done");
    endtask

    task automatic test_async_reset();
        halt_en = 1'b1;
        halt_pc = 4'd3;
        out_ready = 1'b0;
        do_clear();
        for (int i = 0; i < 4; i++) retire(i);
        pulse_drain();
        tick();
        checks++;
        if (out_valid !== 1'b1 || halted !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got v=%b h=%b expected v=1 h=1", out_valid, halted);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || halted !== 1'b0 || count !== 4'd0 || out_pc !== '0 ||
            out_instr !== '0 || out_cycle !== '0 || out_last !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: got v=%b h=%b count=%0d pc=%0d instr=%h cyc=%0d last=%b done=%b expected all 0",
                     out_valid, halted, count, out_pc, out_instr, out_cycle, out_last, done);
        end
        #2;
        reset = 1'b1;
        retire(4);
        checks++;
        if (count !== 4'd1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL areset_resume: got count=%0d h=%b expected count=1 h=0", count, halted);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_watchdog();
        test_empty_drain();
        test_clear_mid_drain();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
